// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - buffers JK commands in a FIFO and replays each as a gap-free burst of {j,k,valid} beats
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_rpt,
  input  logic                     abort,
  output logic                     j,
  output logic                     k,
  output logic                     valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CNT_W + 2;
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, state_n;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] rem, rem_n;
  logic             j_n, k_n, valid_n;
  logic             push, pop;
  logic [EW-1:0]    head;

  assign head       = mem[rd_ptr];
  // A full FIFO refuses even when a pop happens the same cycle: no pass-through.
  assign cmd_ready  = !reset && !abort && (count != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state == ISSUE) || (count != '0);
  assign fifo_count = count;

  always_comb begin
    state_n = state;
    j_n     = j;
    k_n     = k;
    valid_n = valid;
    rem_n   = rem;
    pop     = 1'b0;
    if (abort) begin
      state_n = IDLE;
      j_n     = 1'b0;
      k_n     = 1'b0;
      valid_n = 1'b0;
      rem_n   = '0;
    end else if (state == ISSUE && rem != '0) begin
      rem_n = rem - REM_ONE;
    end else if (count != '0) begin
      // Load the next head directly from IDLE or at the last beat of a burst (zero bubble).
      pop     = 1'b1;
      j_n     = head[EW-1];
      k_n     = head[EW-2];
      valid_n = 1'b1;
      rem_n   = head[CNT_W-1:0];
      state_n = ISSUE;
    end else begin
      j_n     = 1'b0;
      k_n     = 1'b0;
      valid_n = 1'b0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      j     <= 1'b0;
      k     <= 1'b0;
      valid <= 1'b0;
      rem   <= '0;
    end else begin
      state <= state_n;
      j     <= j_n;
      k     <= k_n;
      valid <= valid_n;
      rem   <= rem_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_rpt};
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - scoreboard bench for jk_cmd_sequencer
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_rpt;
  logic       abort;
  logic       j, k, valid, busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  int run_len  = 0;
  int last_run = 0;
  logic [1:0] exp_q[$];

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rpt(cmd_rpt), .abort(abort), .j(j), .k(k),
    .valid(valid), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every issued beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else if (valid) begin
      run_len++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got jk=%0d expected no beat", {j, k});
      end else begin
        check("beat_jk", {j, k}, exp_q.pop_front());
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] rpt);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_rpt   = rpt;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int i = 0; i <= rpt; i++) exp_q.push_back(op);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("idle_reached", int'(busy || valid), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rpt = 4'd0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);

    // 1: single set beat, one edge after accept
    push_cmd(2'b10, 4'd0);
    @(negedge clk);
    check("t1_no_beat_yet", valid, 0);
    check("t1_count", fifo_count, 1);
    @(negedge clk);
    check("t1_beat", valid, 1);
    wait_idle();
    check("t1_run", last_run, 1);

    // 2: toggle x4
    push_cmd(2'b11, 4'd3);
    wait_idle();
    check("t2_run", last_run, 4);

    // 3: long burst keeps FIFO filling; 4 queued, then all bursts gap-free in order
    push_cmd(2'b01, 4'd15);
    push_cmd(2'b10, 4'd1);
    push_cmd(2'b11, 4'd2);
    push_cmd(2'b00, 4'd0);
    push_cmd(2'b01, 4'd1);
    @(negedge clk);
    check("t3_full_count", fifo_count, 4);
    check("t3_full_ready", cmd_ready, 0);
    wait_idle();
    check("t3_run", last_run, 24);

    // 4: max repeat
    push_cmd(2'b01, 4'd15);
    wait_idle();
    check("t4_run", last_run, 16);
    check("t4_count", fifo_count, 0);
    check("t4_busy", busy, 0);

    // 5: async reset mid-burst
    push_cmd(2'b10, 4'd5);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t5_valid", valid, 0);
    check("t5_jk", {j, k}, 0);
    check("t5_count", fifo_count, 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_post_count", fifo_count, 0);
    check("t5_post_busy", busy, 0);
    check("t5_post_ready", cmd_ready, 1);

    // 6: abort with active burst and 3 queued, cmd_valid held high
    push_cmd(2'b10, 4'd7);
    push_cmd(2'b11, 4'd0);
    push_cmd(2'b01, 4'd0);
    push_cmd(2'b00, 4'd0);
    @(negedge clk);
    check("t6_pre_count", fifo_count, 3);
    check("t6_pre_valid", valid, 1);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd2;
    #1;
    check("t6_ready_low", cmd_ready, 0);
    @(posedge clk);
    #1;
    abort = 1'b0; cmd_valid = 1'b0;
    exp_q.delete();
    check("t6_valid", valid, 0);
    check("t6_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    check("t6_no_push", fifo_count, 0);
    check("t6_quiet", valid, 0);
    check("t6_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
